// File: rtl/moore_seq_detector_pkg.sv
// Shared state encodings and pattern constants for the three Moore
// pattern detectors ("001", "110", "1011").
package moore_seq_detector_pkg;

  localparam logic [2:0] PAT_001  = 3'b001;
  localparam logic [2:0] PAT_110  = 3'b110;
  localparam logic [3:0] PAT_1011 = 4'b1011;

  // Each state name records how much of its pattern has been seen so far.
  typedef enum logic [1:0] {
    A0 = 2'd0,
    A1 = 2'd1,
    A2 = 2'd2,
    A3 = 2'd3
  } fsm_001_e;

  typedef enum logic [1:0] {
    B0 = 2'd0,
    B1 = 2'd1,
    B2 = 2'd2,
    B3 = 2'd3
  } fsm_110_e;

  typedef enum logic [2:0] {
    C0 = 3'd0,
    C1 = 3'd1,
    C2 = 3'd2,
    C3 = 3'd3,
    C4 = 3'd4
  } fsm_1011_e;

endpackage

// File: rtl/moore_seq_detector.sv
// Three independent overlapping Moore detectors on one serial input.
// Each flag is registered alongside its state and decodes only that state.
module moore_seq_detector
  import moore_seq_detector_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic in_seq,
  output logic out_seq,
  output logic det_001,
  output logic det_110
);

  fsm_001_e  a_state_q, a_state_d;
  fsm_110_e  b_state_q, b_state_d;
  fsm_1011_e c_state_q, c_state_d;
  logic      det_001_q, det_001_d;
  logic      det_110_q, det_110_d;
  logic      out_seq_q, out_seq_d;

  always_comb begin
    a_state_d = A0;
    case (a_state_q)
      A0:      a_state_d = in_seq ? A0 : A1;
      A1:      a_state_d = in_seq ? A0 : A2;
      A2:      a_state_d = in_seq ? A3 : A2;
      A3:      a_state_d = in_seq ? A0 : A1;
      default: a_state_d = A0;
    endcase
    det_001_d = (a_state_d == A3);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_state_q <= A0;
      det_001_q <= 1'b0;
    end else begin
      a_state_q <= a_state_d;
      det_001_q <= det_001_d;
    end
  end

  always_comb begin
    b_state_d = B0;
    case (b_state_q)
      B0:      b_state_d = in_seq ? B1 : B0;
      B1:      b_state_d = in_seq ? B2 : B0;
      B2:      b_state_d = in_seq ? B2 : B3;
      B3:      b_state_d = in_seq ? B1 : B0;
      default: b_state_d = B0;
    endcase
    det_110_d = (b_state_d == B3);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      b_state_q <= B0;
      det_110_q <= 1'b0;
    end else begin
      b_state_q <= b_state_d;
      det_110_q <= det_110_d;
    end
  end

  // Encodings 5..7 are unreachable; the default arm recovers them to idle.
  always_comb begin
    c_state_d = C0;
    case (c_state_q)
      C0:      c_state_d = in_seq ? C1 : C0;
      C1:      c_state_d = in_seq ? C1 : C2;
      C2:      c_state_d = in_seq ? C3 : C0;
      C3:      c_state_d = in_seq ? C4 : C2;
      C4:      c_state_d = in_seq ? C1 : C2;
      default: c_state_d = C0;
    endcase
    out_seq_d = (c_state_d == C4);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      c_state_q <= C0;
      out_seq_q <= 1'b0;
    end else begin
      c_state_q <= c_state_d;
      out_seq_q <= out_seq_d;
    end
  end

  assign det_001 = det_001_q;
  assign det_110 = det_110_q;
  assign out_seq = out_seq_q;

endmodule

// File: tb/tb_moore_seq_detector.sv
// Self-checking bench: directed pattern sequences with literal expectations,
// then random bits against a history-matching reference model.
module tb_moore_seq_detector;

  logic clk;
  logic reset;
  logic in_seq;
  logic out_seq;
  logic det_001;
  logic det_110;

  int checks = 0;
  int errors = 0;

  // Reference model: the bits seen since the last reset, newest in bit 0.
  logic [3:0] hist = 4'b0000;
  int         hist_len = 0;

  moore_seq_detector dut (
    .clk     (clk),
    .reset   (reset),
    .in_seq  (in_seq),
    .out_seq (out_seq),
    .det_001 (det_001),
    .det_110 (det_110)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_all_low(input string tag);
    check({tag, ".out_seq"}, out_seq, 1'b0);
    check({tag, ".det_001"}, det_001, 1'b0);
    check({tag, ".det_110"}, det_110, 1'b0);
  endtask

  task automatic model_push(input logic b);
    hist = {hist[2:0], b};
    hist_len++;
  endtask

  // Asserts reset between edges, checks the flags fall without a clock,
  // then releases reset on the following falling edge.
  task automatic pulse_reset(input string tag);
    #2 reset = 1'b0;
    #1 check_all_low(tag);
    @(negedge clk);
    reset = 1'b1;
    hist = 4'b0000;
    hist_len = 0;
  endtask

  // One bit per cycle, oldest bit in the highest used position of 'bits'.
  task automatic apply_directed(input string tag, input logic [15:0] bits, input int n,
                                input logic [15:0] e_out, input logic [15:0] e_001,
                                input logic [15:0] e_110);
    for (int i = n - 1; i >= 0; i--) begin
      in_seq = bits[i];
      @(posedge clk);
      #1;
      model_push(bits[i]);
      check($sformatf("%s.bit%0d.out_seq", tag, n - i), out_seq, e_out[i]);
      check($sformatf("%s.bit%0d.det_001", tag, n - i), det_001, e_001[i]);
      check($sformatf("%s.bit%0d.det_110", tag, n - i), det_110, e_110[i]);
    end
  endtask

  task automatic apply_random(input int idx);
    logic b;
    logic exp_out, exp_001, exp_110;
    b = 1'($urandom_range(1, 0));
    in_seq = b;
    @(posedge clk);
    #1;
    model_push(b);
    exp_001 = (hist_len >= 3) && (hist[2:0] == 3'b001);
    exp_110 = (hist_len >= 3) && (hist[2:0] == 3'b110);
    exp_out = (hist_len >= 4) && (hist == 4'b1011);
    check($sformatf("rand%0d.out_seq", idx), out_seq, exp_out);
    check($sformatf("rand%0d.det_001", idx), det_001, exp_001);
    check($sformatf("rand%0d.det_110", idx), det_110, exp_110);
  endtask

  initial begin
    reset  = 1'b0;
    in_seq = 1'b0;
    #1 check_all_low("reset_async");

    // Reset held through three edges while the input toggles.
    for (int i = 0; i < 3; i++) begin
      in_seq = ~in_seq;
      @(posedge clk);
      #1 check_all_low($sformatf("reset_hold%0d", i));
    end
    @(negedge clk);
    reset = 1'b1;

    apply_directed("mixed", 16'(11'b11001111001), 11,
                   16'(11'b00000000000), 16'(11'b00001000001), 16'(11'b00100000100));
    pulse_reset("mixed_rst");

    apply_directed("overlap1011", 16'(7'b1011011), 7,
                   16'(7'b0001001), 16'(7'b0000000), 16'(7'b0000100));
    pulse_reset("flag_async_drop");

    apply_directed("partial101", 16'(3'b101), 3,
                   16'(3'b000), 16'(3'b000), 16'(3'b000));
    pulse_reset("partial_rst");
    apply_directed("after_rst1", 16'(1'b1), 1,
                   16'(1'b0), 16'(1'b0), 16'(1'b0));
    pulse_reset("after_rst1_rst");

    apply_directed("zeros_then1", 16'(5'b00001), 5,
                   16'(5'b00000), 16'(5'b00001), 16'(5'b00000));
    pulse_reset("zeros_rst");
    apply_directed("ones_then0", 16'(5'b11110), 5,
                   16'(5'b00000), 16'(5'b00000), 16'(5'b00001));
    pulse_reset("ones_rst");

    for (int i = 0; i < 400; i++) begin
      if ((i % 97) == 96) pulse_reset($sformatf("rand_rst%0d", i));
      apply_random(i);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
